// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the button conditioner: debounce default, long-press
// multiplier and button indices.
package btn_conditioner_pkg;

    localparam int unsigned DEFAULT_DB_CYCLES = 16;
    localparam int unsigned HOLD_MULT         = 4;
    localparam int unsigned NUM_BTNS          = 3;

    typedef enum int unsigned {
        RUN  = 0,
        CLR  = 1,
        MODE = 2
    } btn_idx_e;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchronizer, stability counter,
// accepted level and a registered one-cycle press (0->1) pulse.
module btn_debounce
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          sample;

    assign sample = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sample == level) begin
                // any return to the accepted level drops partial progress
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sample;
                cnt   <= '0;
                press <= sample;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Run/clear/style conditioner for a downstream counter. Optional macro
// BTN_COND_HOLD_CLR_EN turns CLR into a long-press (HOLD_MULT*DB_CYCLES) action.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_RUN,
    input  logic BTN_CLR,
    input  logic BTN_MODE,
    output logic EN,
    output logic RST,
    output logic STYLE
);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] press;
    logic                clr_evt;
    logic                unused_sig;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (BTN_RUN),
        .level (level[RUN]),
        .press (press[RUN])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (BTN_CLR),
        .level (level[CLR]),
        .press (press[CLR])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (
        .clk   (CLK),
        .rst_n (RST_N),
        .raw   (BTN_MODE),
        .level (level[MODE]),
        .press (press[MODE])
    );

    assign unused_sig = ^{level, press};

`ifdef BTN_COND_HOLD_CLR_EN
    localparam int unsigned HOLD_CYCLES = HOLD_MULT * DB_CYCLES;
    localparam int unsigned HW          = $clog2(HOLD_CYCLES);

    logic [HW-1:0] hold_cnt;
    logic          hold_done;

    // counts edges with the debounced CLR level high; fires once per hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
            clr_evt   <= 1'b0;
        end else if (!level[CLR]) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
            clr_evt   <= 1'b0;
        end else begin
            clr_evt <= 1'b0;
            if (!hold_done) begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    hold_done <= 1'b1;
                    clr_evt   <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end
`else
    assign clr_evt = press[CLR];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EN    <= 1'b0;
            RST   <= 1'b0;
            STYLE <= 1'b0;
        end else begin
            RST <= clr_evt;
            if (clr_evt) begin
                EN <= 1'b0;
            end else if (press[RUN]) begin
                EN <= ~EN;
            end
            if (press[MODE]) begin
                STYLE <= ~STYLE;
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized + directed bench for btn_conditioner (DB_CYCLES=4) against a
// window-based reference model; honours BTN_COND_HOLD_CLR_EN when defined.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = HOLD_MULT * DB;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic BTN_RUN = 1'b0, BTN_CLR = 1'b0, BTN_MODE = 1'b0;
    logic EN, RST, STYLE;

    int n_cmp = 0;
    int n_err = 0;

    btn_conditioner #(.DB_CYCLES(DB)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_RUN  (BTN_RUN),
        .BTN_CLR  (BTN_CLR),
        .BTN_MODE (BTN_MODE),
        .EN       (EN),
        .RST      (RST),
        .STYLE    (STYLE)
    );

    always #5 CLK = ~CLK;

    // Reference model: a level is accepted once the last DB synchronized
    // samples all differ from it; effects appear one edge after acceptance.
    bit          d1[3], d2[3], lvl[3];
    bit          win[3][$];
    bit          p_run, p_clr, p_mode;
    bit          m_en, m_rst, m_style;
    int unsigned hcnt;

    function automatic void model_clear();
        for (int b = 0; b < 3; b++) begin
            d1[b] = 0; d2[b] = 0; lvl[b] = 0;
            win[b].delete();
        end
        p_run = 0; p_clr = 0; p_mode = 0;
        m_en = 0; m_rst = 0; m_style = 0;
        hcnt = 0;
    endfunction

    function automatic void model_edge();
        bit raw[3];
        bit pr[3];
        bit samp, all_diff, hold_evt;
        raw[0] = BTN_RUN; raw[1] = BTN_CLR; raw[2] = BTN_MODE;
        m_rst = p_clr;
        if (p_clr) m_en = 0;
        else if (p_run) m_en = !m_en;
        if (p_mode) m_style = !m_style;
        if (lvl[1]) hcnt++;
        else hcnt = 0;
        hold_evt = (hcnt == HOLD);
        for (int b = 0; b < 3; b++) begin
            samp  = d2[b];
            d2[b] = d1[b];
            d1[b] = raw[b];
            win[b].push_back(samp);
            if (win[b].size() > DB) void'(win[b].pop_front());
            all_diff = (win[b].size() == DB);
            foreach (win[b][i]) if (win[b][i] == lvl[b]) all_diff = 0;
            pr[b] = 0;
            if (all_diff) begin
                lvl[b] = samp;
                pr[b]  = samp;
            end
        end
        p_run  = pr[0];
        p_mode = pr[2];
`ifdef BTN_COND_HOLD_CLR_EN
        p_clr = hold_evt;
`else
        p_clr = pr[1];
`endif
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_clear();
        else model_edge();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive at a falling edge, advance one rising edge, compare at next falling edge
    task automatic step(input logic r, input logic c, input logic m);
        BTN_RUN = r; BTN_CLR = c; BTN_MODE = m;
        @(posedge CLK);
        @(negedge CLK);
        check("model", {29'd0, EN, RST, STYLE}, {29'd0, m_en, m_rst, m_style});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        BTN_RUN = 0; BTN_CLR = 0; BTN_MODE = 0;
        RST_N = 0;
        #1 check("reset", {29'd0, EN, RST, STYLE}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        bit          cur[3];
        int unsigned rem[3];

        // run press latency and single event on long hold
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0);
            check("run_latency", {31'd0, EN}, {31'd0, k >= 7});
        end
        idle(8);
        check("run_release", {31'd0, EN}, 32'd1);

        // short mode glitch, then valid press
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0);
            check("mode_glitch", {31'd0, STYLE}, 32'd0);
        end
        for (int k = 0; k < 5; k++) step(0, 0, 1);
        idle(6);
        check("mode_press", {31'd0, STYLE}, 32'd1);

`ifndef BTN_COND_HOLD_CLR_EN
        // clear pulse with EN set and STYLE set
        do_reset();
        for (int k = 0; k < 8; k++) step(1, 0, 0);
        idle(8);
        for (int k = 0; k < 8; k++) step(0, 0, 1);
        idle(8);
        check("pre_clr_en", {31'd0, EN}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0);
            check("clr_pulse", {31'd0, RST}, {31'd0, k == 7});
            check("clr_en", {31'd0, EN}, {31'd0, k < 7});
            check("clr_style", {31'd0, STYLE}, 32'd1);
        end
        idle(8);

        // simultaneous run and clear: clear wins
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 0);
            check("both_rst", {31'd0, RST}, {31'd0, k == 7});
            check("both_en", {31'd0, EN}, 32'd0);
        end
        idle(8);
`endif

        // reset mid-count discards progress; held button fires 7 edges later
        do_reset();
        for (int k = 0; k < 8; k++) step(1, 0, 0);
        idle(8);
        for (int k = 0; k < 8; k++) step(0, 0, 1);
        idle(8);
        for (int k = 0; k < 4; k++) step(1, 0, 0);
        RST_N = 0;
        #1 check("midreset_outs", {29'd0, EN, RST, STYLE}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1;
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 0);
            check("held_after_reset", {31'd0, EN}, {31'd0, k >= 7});
        end
        idle(8);

`ifdef BTN_COND_HOLD_CLR_EN
        // long-press clear: short hold silent, long hold pulses once at edge 23
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0);
            check("hold_short", {31'd0, RST}, 32'd0);
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0);
            check("hold_short_rel", {31'd0, RST}, 32'd0);
        end
        for (int k = 1; k <= 30; k++) begin
            step(0, 1, 0);
            check("hold_long", {31'd0, RST}, {31'd0, k == 23});
        end
        idle(10);
`endif

        // randomized segments against the model, with one reset midway
        do_reset();
        for (int b = 0; b < 3; b++) begin
            cur[b] = 0;
            rem[b] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) begin
                do_reset();
                for (int b = 0; b < 3; b++) rem[b] = 0;
            end
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    cur[b] = $urandom_range(0, 1) != 0;
                    rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(3, 28);
                end
                rem[b]--;
            end
            step(cur[0], cur[1], cur[2]);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
